// File: rtl/cnt_down_timer_if.sv
// Control and display bundle for the MM:SS:CC countdown timer.
// The master drives the controls and presets; the slave is the timer itself.
interface cnt_down_timer_if;
  logic       load;
  logic [6:0] load_min;
  logic [6:0] load_sec;
  logic [6:0] load_cs;
  logic       start;
  logic       pause;
  logic [6:0] min;
  logic [6:0] sec;
  logic [6:0] cs;
  logic       running;
  logic       cs_tick;
  logic       done;

  modport master (
    output load, load_min, load_sec, load_cs, start, pause,
    input  min, sec, cs, running, cs_tick, done
  );

  modport slave (
    input  load, load_min, load_sec, load_cs, start, pause,
    output min, sec, cs, running, cs_tick, done
  );
endinterface

// File: rtl/cnt_down_timer.sv
// MM:SS:CC countdown timer: a prescaler paces one borrow-cascade decrement per
// centisecond, and a one-cycle done pulse fires on the edge that reaches 00:00:00.
module cnt_down_timer #(
  parameter int TICK_DIV = 100000
) (
  input logic             clk,
  input logic             rst,
  cnt_down_timer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [PW-1:0] PRE_ZERO = {PW{1'b0}};

  // Presets wider than a digit's range saturate rather than wrap.
  function automatic logic [6:0] clamp_digit(input logic [6:0] v, input logic [6:0] lim);
    if (v > lim) begin
      return lim;
    end else begin
      return v;
    end
  endfunction

  // One step of the borrow cascade; 00:00:00 stays put so nothing underflows.
  function automatic logic [20:0] dec_count(input logic [6:0] m, input logic [6:0] s,
                                            input logic [6:0] c);
    if (c != 7'd0) begin
      return {m, s, c - 7'd1};
    end else if (s != 7'd0) begin
      return {m, s - 7'd1, 7'd99};
    end else if (m != 7'd0) begin
      return {m - 7'd1, 7'd59, 7'd99};
    end else begin
      return 21'd0;
    end
  endfunction

  state_t        state_r, state_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [6:0]    min_r, min_s;
  logic [6:0]    sec_r, sec_s;
  logic [6:0]    cs_r, cs_s;
  logic          running_r, running_s;
  logic          tick_r, tick_s;
  logic          done_r, done_s;
  logic          count_nz_s;
  logic          wrap_s;
  logic          step_s;
  logic [20:0]   dec_s;

  assign count_nz_s = (min_r != 7'd0) || (sec_r != 7'd0) || (cs_r != 7'd0);
  assign wrap_s     = (presc_r == PRE_LAST);
  assign step_s     = (state_r == ST_RUN) && !bus.load && !bus.pause && wrap_s;
  assign dec_s      = dec_count(min_r, sec_r, cs_r);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; load beats pause, pause beats start.
  always_comb begin
    state_s = state_r;
    if (bus.load) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start && !bus.pause && count_nz_s) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_s = ST_PAUSED;
          end else if (step_s && (dec_s == 21'd0)) begin
            state_s = ST_EXPIRED;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_PAUSED: begin
          if (bus.start && !bus.pause) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_PAUSED;
          end
        end
        ST_EXPIRED: state_s = ST_EXPIRED;
        default:    state_s = ST_IDLE;
      endcase
    end
  end

  // Next values of the count, prescaler and pulse outputs.
  always_comb begin
    presc_s = presc_r;
    min_s   = min_r;
    sec_s   = sec_r;
    cs_s    = cs_r;
    tick_s  = 1'b0;
    done_s  = 1'b0;
    if (bus.load) begin
      presc_s = PRE_ZERO;
      min_s   = clamp_digit(bus.load_min, 7'd99);
      sec_s   = clamp_digit(bus.load_sec, 7'd59);
      cs_s    = clamp_digit(bus.load_cs, 7'd99);
    end else if ((state_r == ST_RUN) && !bus.pause) begin
      if (wrap_s) begin
        presc_s              = PRE_ZERO;
        {min_s, sec_s, cs_s} = dec_s;
        tick_s               = 1'b1;
        done_s               = (dec_s == 21'd0);
      end else begin
        presc_s = presc_r + PRE_ONE;
      end
    end else begin
      presc_s = presc_r;
    end
    running_s = (state_s == ST_RUN);
  end

  // Datapath and output registers; a paused prescaler simply holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r   <= PRE_ZERO;
      min_r     <= 7'd0;
      sec_r     <= 7'd0;
      cs_r      <= 7'd0;
      running_r <= 1'b0;
      tick_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      presc_r   <= presc_s;
      min_r     <= min_s;
      sec_r     <= sec_s;
      cs_r      <= cs_s;
      running_r <= running_s;
      tick_r    <= tick_s;
      done_r    <= done_s;
    end
  end

  assign bus.min     = min_r;
  assign bus.sec     = sec_r;
  assign bus.cs      = cs_r;
  assign bus.running = running_r;
  assign bus.cs_tick = tick_r;
  assign bus.done    = done_r;

  logic unused_s;
  assign unused_s = step_s & 1'b0;

endmodule

// File: tb/tb_cnt_down_timer.sv
// Directed bench: two timers (TICK_DIV=1 and 4) share one stimulus stream and are
// scored against a model that counts in total centiseconds.
module tb_cnt_down_timer;

  typedef struct packed {
    logic [6:0] mn;
    logic [6:0] sc;
    logic [6:0] c;
    logic       run;
    logic       tk;
    logic       dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [6:0] lmin = 7'd0;
  logic [6:0] lsec = 7'd0;
  logic [6:0] lcs = 7'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  string phase = "init";

  int m_st[2]  = '{0, 0};
  int m_tot[2] = '{0, 0};
  int m_pre[2] = '{0, 0};
  bit m_tk[2]  = '{1'b0, 1'b0};
  bit m_dn[2]  = '{1'b0, 1'b0};
  int td[2]    = '{1, 4};

  cnt_down_timer_if if1 ();
  cnt_down_timer_if if4 ();

  assign if1.load = load;   assign if4.load = load;
  assign if1.load_min = lmin; assign if4.load_min = lmin;
  assign if1.load_sec = lsec; assign if4.load_sec = lsec;
  assign if1.load_cs = lcs;   assign if4.load_cs = lcs;
  assign if1.start = start; assign if4.start = start;
  assign if1.pause = pause; assign if4.pause = pause;

  cnt_down_timer #(.TICK_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  cnt_down_timer #(.TICK_DIV(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  always #5 clk = ~clk;

  function automatic int cl(input logic [6:0] v, input int lim);
    return (int'(v) > lim) ? lim : int'(v);
  endfunction

  // Reference: 0 IDLE, 1 RUN, 2 PAUSED, 3 EXPIRED; the count is one integer.
  task automatic model_step(input int k);
    m_tk[k] = 1'b0;
    m_dn[k] = 1'b0;
    if (rst) begin
      m_tot[k] = 0; m_pre[k] = 0; m_st[k] = 0;
    end else if (load) begin
      m_tot[k] = cl(lmin, 99) * 6000 + cl(lsec, 59) * 100 + cl(lcs, 99);
      m_pre[k] = 0; m_st[k] = 0;
    end else begin
      case (m_st[k])
        0: if (start && !pause && m_tot[k] != 0) m_st[k] = 1;
        1: begin
          if (pause) m_st[k] = 2;
          else if (m_pre[k] == td[k] - 1) begin
            m_pre[k] = 0;
            m_tot[k] = m_tot[k] - 1;
            m_tk[k] = 1'b1;
            if (m_tot[k] == 0) begin m_dn[k] = 1'b1; m_st[k] = 3; end
          end else m_pre[k] = m_pre[k] + 1;
        end
        2: if (start && !pause) m_st[k] = 1;
        default: ;
      endcase
    end
  endtask

  function automatic exp_t model_out(input int k);
    exp_t e;
    e.mn  = 7'(m_tot[k] / 6000);
    e.sc  = 7'((m_tot[k] / 100) % 60);
    e.c   = 7'(m_tot[k] % 100);
    e.run = (m_st[k] == 1);
    e.tk  = m_tk[k];
    e.dn  = m_dn[k];
    return e;
  endfunction

  function automatic exp_t dut_out(input int k);
    exp_t o;
    if (k == 0) o = '{if1.min, if1.sec, if1.cs, if1.running, if1.cs_tick, if1.done};
    else        o = '{if4.min, if4.sec, if4.cs, if4.running, if4.cs_tick, if4.done};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: push model expectations, let the DUTs clock, pop and compare.
  task automatic cycle();
    exp_t e, o;
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      q.push_back(model_out(k));
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e = q.pop_front();
      o = dut_out(k);
      chk($sformatf("%s/d%0d/min", phase, td[k]), o.mn, e.mn);
      chk($sformatf("%s/d%0d/sec", phase, td[k]), o.sc, e.sc);
      chk($sformatf("%s/d%0d/cs", phase, td[k]), o.c, e.c);
      chk($sformatf("%s/d%0d/running", phase, td[k]), {6'd0, o.run}, {6'd0, e.run});
      chk($sformatf("%s/d%0d/cs_tick", phase, td[k]), {6'd0, o.tk}, {6'd0, e.tk});
      chk($sformatf("%s/d%0d/done", phase, td[k]), {6'd0, o.dn}, {6'd0, e.dn});
    end
  endtask

  task automatic do_load(input logic [6:0] m, input logic [6:0] s, input logic [6:0] c);
    load = 1'b1; lmin = m; lsec = s; lcs = c;
    cycle();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    int dn_cnt;
    int dn_at;
    logic [6:0] fm, fs, fc;

    phase = "T1_reset";
    rst = 1'b1;
    cycle();
    cycle();
    chk("T1/running", {6'd0, if1.running}, 7'd0);
    rst = 1'b0;
    cycle();

    phase = "T2_countdown";
    do_load(7'd0, 7'd1, 7'd2);
    do_start();
    chk("T2/running_after_start", {6'd0, if1.running}, 7'd1);
    dn_cnt = 0;
    dn_at = 0;
    for (int i = 1; i <= 110; i++) begin
      cycle();
      if (i == 1) chk("T2/first_cs", if1.cs, 7'd1);
      if (i == 3) chk("T2/borrow_cs", if1.cs, 7'd99);
      if (if1.done === 1'b1) begin dn_cnt++; dn_at = i; end
    end
    chk("T2/done_count", 7'(dn_cnt), 7'd1);
    chk("T2/done_cycle", 7'(dn_at), 7'd102);

    phase = "T3_min_borrow";
    do_load(7'd1, 7'd0, 7'd0);
    do_start();
    cycle();
    chk("T3/min", if1.min, 7'd0);
    chk("T3/sec", if1.sec, 7'd59);
    chk("T3/cs", if1.cs, 7'd99);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("T3/tick_each", {6'd0, if1.cs_tick}, 7'd1);
    end

    phase = "T4_clamp";
    do_load(7'd127, 7'd75, 7'd120);
    chk("T4/min", if1.min, 7'd99);
    chk("T4/sec", if4.sec, 7'd59);
    chk("T4/cs", if1.cs, 7'd99);
    do_load(7'd0, 7'd0, 7'd0);
    start = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    start = 1'b0;
    chk("T4/zero_running", {6'd0, if4.running}, 7'd0);
    chk("T4/zero_done", {6'd0, if1.done}, 7'd0);

    phase = "T5_pause";
    do_load(7'd0, 7'd10, 7'd0);
    do_start();
    for (int i = 0; i < 6; i++) cycle();
    pause = 1'b1;
    cycle();
    fm = if4.min; fs = if4.sec; fc = if4.cs;
    for (int i = 0; i < 9; i++) cycle();
    chk("T5/frozen_sec", if4.sec, fs);
    chk("T5/frozen_cs", if4.cs, fc);
    chk("T5/frozen_min", if4.min, fm);
    pause = 1'b0;
    do_start();
    cycle();
    chk("T5/no_tick_1", {6'd0, if4.cs_tick}, 7'd0);
    cycle();
    chk("T5/tick_2", {6'd0, if4.cs_tick}, 7'd1);

    phase = "T6_misc";
    start = 1'b1; pause = 1'b1;
    cycle();
    start = 1'b0; pause = 1'b0;
    chk("T6/both_running", {6'd0, if4.running}, 7'd0);
    do_load(7'd0, 7'd0, 7'd3);
    do_start();
    for (int i = 0; i < 14; i++) cycle();
    start = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    start = 1'b0;
    chk("T6/expired_running", {6'd0, if4.running}, 7'd0);
    chk("T6/expired_cs", if4.cs, 7'd0);
    do_load(7'd0, 7'd0, 7'd50);
    do_start();
    for (int i = 0; i < 5; i++) cycle();
    do_load(7'd0, 7'd2, 7'd0);
    chk("T6/load_sec", if1.sec, 7'd2);
    chk("T6/load_tick", {6'd0, if1.cs_tick}, 7'd0);
    chk("T6/load_running", {6'd0, if4.running}, 7'd0);

    phase = "T7_rst_run";
    do_start();
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("T7/sec", if1.sec, 7'd0);
    chk("T7/done", {6'd0, if1.done}, 7'd0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
